rv_reg_file_2r1w: RTL and testbench
===================================

Name: rv_reg_file_2r1w

Overview:
- RISC-V integer register file for the datapath: 32 architectural registers, one write port, two registered read ports.
- Reads have 1-cycle latency with per-port valid strobes, so decode can issue rs1/rs2 lookups and consume operands the next cycle.
- Writes come from the writeback stage; x0 is hardwired to zero.

Parameters:
- n, 32, data width of each register in bits.
- ADDR_W, 5, register index width.
- DEPTH, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- we  input  1  write enable from writeback.
- waddr  input  ADDR_W  write register index.
- wdata  input  n  write data.
- re1  input  1  read request, port 1 (rs1).
- raddr1  input  ADDR_W  read index, port 1.
- re2  input  1  read request, port 2 (rs2).
- raddr2  input  ADDR_W  read index, port 2.
- rdata1  output  n  registered read data, port 1.
- rvalid1  output  1  rdata1 valid strobe.
- rdata2  output  n  registered read data, port 2.
- rvalid2  output  1  rdata2 valid strobe.

Behaviour:
- Reset:
  - rst low clears all DEPTH registers, rdata1, rdata2, rvalid1 and rvalid2 to 0, immediately and independent of clk.
  - Release is sampled on the next rising clk edge.
- Write:
  - On a rising edge with we=1 and waddr!=0, regs[waddr] <= wdata.
  - we=1 with waddr=0 is ignored; regs[0] reads 0 forever.
- Read, per port k:
  - On a rising edge with rek=1, rdatak <= value of regs[raddrk] and rvalidk <= 1.
  - With rek=0, rvalidk <= 0 and rdatak holds its previous value.
  - Latency is exactly 1 cycle; back-to-back requests give one result per cycle.
- raddrk=0 always returns 0, including when the same edge writes waddr=0.
- Both ports may read the same address in the same cycle; both return identical data.
- Read-during-write to the same nonzero address on the same edge: governed by WRITE_BYPASS_EN (below).
- Reset asserted mid-stream: any pending valid is dropped. No result is produced for requests sampled in the cycle reset asserts.
- No backpressure: the consumer must take rdatak in the cycle rvalidk=1, or rely on the held value until the next request.

Optional Feature:
- Macro: RV_REG_FILE_WRITE_BYPASS_EN.
- Defined: a same-edge write to the address being read is forwarded, so rdatak = wdata (write-first). The x0 rule still wins.
- Undefined: rdatak returns the pre-write contents (read-first). The new value is visible to requests on the following edge.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32;
  - constant REG_ZERO=5'd0;
  - typedefs reg_addr_t and xlen_t.
- One sub-module, rv_reg_read_port, instantiated twice. It takes re, raddr, the storage array view and the write-side signals, and produces registered rdata/rvalid, including the x0 and bypass logic.
- Storage and write logic stay in the top.

Test Plan:
- Reset: drive rst=0 mid-run after writing x5=0xDEADBEEF, then release and read x5 -> rdata1=0x00000000, rvalid1=1 one cycle after re1. Both rvalids are 0 during reset.
- Basic write/read: write x1=0x12345678, next cycle re1=1 raddr1=1 -> one cycle later rdata1=0x12345678, rvalid1=1. re1=0 on the next cycle -> rvalid1=0, rdata1 held.
- x0 protection: we=1 waddr=0 wdata=0xFFFFFFFF, then read x0 on both ports -> rdata1=rdata2=0, rvalid1=rvalid2=1.
- Dual port: x3=0xA5A5A5A5, x4=0x5A5A5A5A; same-cycle reads raddr1=3 and raddr2=4 -> rdata1=0xA5A5A5A5, rdata2=0x5A5A5A5A in the same cycle. Repeat with both ports on x3 -> both 0xA5A5A5A5.
- Read-during-write: x7=0x11111111, then a same edge with we=1 waddr=7 wdata=0x22222222 and re1=1 raddr1=7 -> rdata1=0x22222222 with the macro defined, 0x11111111 without it. Either way, the next read of x7 gives 0x22222222.
- Streaming: re2=1 for 32 consecutive cycles with raddr2=0..31 after writing regs[i]=i*4 -> rvalid2 high for 32 consecutive cycles, rdata2 sequence 0,4,8,...,124 (x0 reads 0), one cycle behind the addresses.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V datapath constants and types.
// Holds the register file geometry (XLEN, REG_ADDR_W, NUM_REGS), the x0
// index constant and the register address / data typedefs.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : rv_pkg

// File: rtl/rv_reg_read_port.sv
// One registered read port of the integer register file.
// Build option: RV_REG_FILE_WRITE_BYPASS_EN selects write-first forwarding
// of a same-edge write; otherwise the port returns pre-write contents.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_re, i_raddr     read request and register index
//   i_regs            view of the storage array
//   i_we, i_waddr,
//   i_wdata           write-side signals for the same edge (bypass)
//   o_rdata, o_rvalid registered read data and its valid strobe
module rv_reg_read_port
    import rv_pkg::*;
#(
    parameter int unsigned N      = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [N-1:0]      i_regs [DEPTH],
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [N-1:0]      i_wdata,
    output logic [N-1:0]      o_rdata,
    output logic              o_rvalid
);

    logic [N-1:0] w_rd_val;

    // Select the value captured on this edge; x0 overrides everything.
    always_comb begin
        w_rd_val = i_regs[i_raddr];
`ifdef RV_REG_FILE_WRITE_BYPASS_EN
        if (i_we && (i_waddr == i_raddr)) begin
            w_rd_val = i_wdata;
        end
`endif
        if (i_raddr == ADDR_W'(REG_ZERO)) begin
            w_rd_val = '0;
        end
    end

`ifndef RV_REG_FILE_WRITE_BYPASS_EN
    // Write-side inputs only feed the forwarding path.
    logic w_unused_wr;
    assign w_unused_wr = ^{i_we, i_waddr, i_wdata};
`endif

    // Data holds when no request; valid follows the request one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= i_re;
            if (i_re) begin
                o_rdata <= w_rd_val;
            end
        end
    end

endmodule : rv_reg_read_port

// File: rtl/rv_reg_file_2r1w.sv
// RISC-V integer register file: 32 registers, one write port, two
// registered read ports with 1-cycle latency and valid strobes. x0 reads 0.
// Build option: RV_REG_FILE_WRITE_BYPASS_EN (write-first read-during-write);
// undefined gives read-first behaviour.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   we, waddr, wdata         writeback write port
//   re1, raddr1 / re2, raddr2 read requests (rs1 / rs2)
//   rdata1, rvalid1 / rdata2, rvalid2 registered read results
module rv_reg_file_2r1w
    import rv_pkg::*;
#(
    parameter int unsigned n      = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [n-1:0]      wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [n-1:0]      rdata1,
    output logic              rvalid1,
    output logic [n-1:0]      rdata2,
    output logic              rvalid2
);

    // Full decode of the index space is assumed by the read mux.
    if (DEPTH != 2**ADDR_W) begin : g_depth_chk
        $error("rv_reg_file_2r1w: DEPTH must equal 2**ADDR_W");
    end

    logic [n-1:0] r_regs [DEPTH];
    logic         w_wr_en;

    // Writes to x0 are dropped so it stays zero.
    assign w_wr_en = we && (waddr != ADDR_W'(REG_ZERO));

    // Storage array with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    rv_reg_read_port #(
        .N      (n),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd_port1 (
        .clk      (clk),
        .rst_n    (rst),
        .i_re     (re1),
        .i_raddr  (raddr1),
        .i_regs   (r_regs),
        .i_we     (w_wr_en),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .o_rdata  (rdata1),
        .o_rvalid (rvalid1)
    );

    rv_reg_read_port #(
        .N      (n),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd_port2 (
        .clk      (clk),
        .rst_n    (rst),
        .i_re     (re2),
        .i_raddr  (raddr2),
        .i_regs   (r_regs),
        .i_we     (w_wr_en),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .o_rdata  (rdata2),
        .o_rvalid (rvalid2)
    );

endmodule : rv_reg_file_2r1w

// File: tb/tb_rv_reg_file_2r1w.sv
// Self-checking bench for rv_reg_file_2r1w: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_rv_reg_file_2r1w;

`ifdef RV_REG_FILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic        rvalid1;
    logic [31:0] rdata2;
    logic        rvalid2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] mem [32];
    logic [31:0] exp_d1, exp_d2;
    logic        exp_v1, exp_v2;

    rv_reg_file_2r1w dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .rdata2  (rdata2),
        .rvalid2 (rvalid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && we && (waddr == a)) return wdata;
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        exp_d1 = 32'h0; exp_d2 = 32'h0;
        exp_v1 = 1'b0;  exp_v2 = 1'b0;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0;
        re2 = 1'b0; raddr2 = 5'd0;
    endtask

    // One clock: advance the model at the edge, then compare just after it.
    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            exp_v1 = re1;
            exp_v2 = re2;
            if (re1) exp_d1 = model_read(raddr1);
            if (re2) exp_d2 = model_read(raddr2);
            if (we && waddr != 5'd0) mem[waddr] = wdata;
        end
        #1;
        check("model_rvalid1", {31'h0, rvalid1}, {31'h0, exp_v1});
        check("model_rdata1", rdata1, exp_d1);
        check("model_rvalid2", {31'h0, rvalid2}, {31'h0, exp_v2});
        check("model_rdata2", rdata2, exp_d2);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle(); we = 1'b1; waddr = a; wdata = d;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_clear();
        #1;
        check("reset_rvalid1", {31'h0, rvalid1}, 32'h0);
        check("reset_rvalid2", {31'h0, rvalid2}, 32'h0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // Basic write then read, then hold
        wr(5'd1, 32'h12345678);
        re1 = 1'b1; raddr1 = 5'd1;
        cyc();
        check("basic_rdata1", rdata1, 32'h12345678);
        check("basic_rvalid1", {31'h0, rvalid1}, 32'h1);
        idle();
        cyc();
        check("hold_rvalid1", {31'h0, rvalid1}, 32'h0);
        check("hold_rdata1", rdata1, 32'h12345678);

        // Reset mid-stream clears registers and outputs
        wr(5'd5, 32'hDEADBEEF);
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd1;
        rst = 1'b0;
        #1;
        model_clear();
        check("rst_async_rvalid1", {31'h0, rvalid1}, 32'h0);
        check("rst_async_rvalid2", {31'h0, rvalid2}, 32'h0);
        check("rst_async_rdata1", rdata1, 32'h0);
        cyc();
        check("rst_drop_rvalid2", {31'h0, rvalid2}, 32'h0);
        rst = 1'b1;
        idle();
        re1 = 1'b1; raddr1 = 5'd5;
        cyc();
        check("rst_x5_rdata1", rdata1, 32'h0);
        check("rst_x5_rvalid1", {31'h0, rvalid1}, 32'h1);
        idle();

        // x0 protection, including read on the same edge as the x0 write
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        cyc();
        check("x0_same_edge", rdata1, 32'h0);
        idle();
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        cyc();
        check("x0_rdata1", rdata1, 32'h0);
        check("x0_rdata2", rdata2, 32'h0);
        check("x0_rvalid2", {31'h0, rvalid2}, 32'h1);
        idle();

        // Dual port reads
        wr(5'd3, 32'hA5A5A5A5);
        wr(5'd4, 32'h5A5A5A5A);
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        cyc();
        check("dual_rdata1", rdata1, 32'hA5A5A5A5);
        check("dual_rdata2", rdata2, 32'h5A5A5A5A);
        raddr2 = 5'd3;
        cyc();
        check("same_rdata1", rdata1, 32'hA5A5A5A5);
        check("same_rdata2", rdata2, 32'hA5A5A5A5);
        idle();

        // Read during write
        wr(5'd7, 32'h11111111);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222;
        re1 = 1'b1; raddr1 = 5'd7;
        cyc();
        check("rdw_rdata1", rdata1, BYPASS ? 32'h22222222 : 32'h11111111);
        idle();
        re1 = 1'b1; raddr1 = 5'd7;
        cyc();
        check("rdw_next_rdata1", rdata1, 32'h22222222);
        idle();

        // Streaming 32 back-to-back reads on port 2
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 4));
        for (int i = 0; i < 32; i++) begin
            re2 = 1'b1; raddr2 = 5'(i);
            cyc();
            check("stream_rvalid2", {31'h0, rvalid2}, 32'h1);
            check("stream_rdata2", rdata2, 32'(i * 4));
        end
        idle();
        cyc();
        check("stream_end_rvalid2", {31'h0, rvalid2}, 32'h0);

        // Randomized traffic; narrow address range to force collisions
        for (int k = 0; k < 600; k++) begin
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wdata  = $urandom;
            re1    = 1'($urandom_range(0, 3) != 0);
            raddr1 = 5'($urandom_range(0, 7));
            re2    = 1'($urandom_range(0, 3) != 0);
            raddr2 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            if (k == 300) begin
                rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
            cyc();
        end
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rv_reg_file_2r1w
